rvx_uart_tx_fifo: RTL and testbench
===================================

// Module: rvx_uart_tx_fifo
// PURPOSE
//   Transmit buffer placed upstream of rvx_uart. Software pushes bytes through an IO-bus slave port
//   into a FIFO without waiting for the line. A drain state machine empties the FIFO into the UART.
//   For each byte it polls the UART READY register (0x08). When READY is set, it writes the byte to
//   WDATA (0x00). Freed CPU time is the point: no busy-wait per character.
// PARAMETERS
//   FIFO_DEPTH  16  entries; power of two, >= 2
//   PTR_WIDTH   4   log2(FIFO_DEPTH); level counter is PTR_WIDTH+1 bits
// PORTS
//   clock               in   1   system clock
//   reset_n             in   1   asynchronous, active-low reset
//   rw_address          in   5   CPU-side register address
//   read_data           out  32  CPU-side read data (registered)
//   read_request        in   1   CPU-side read strobe
//   read_response       out  1   CPU-side read ack
//   write_data          in   8   CPU-side write byte
//   write_request       in   1   CPU-side write strobe
//   write_response      out  1   CPU-side write ack
//   uart_rw_address     out  5   to rvx_uart rw_address
//   uart_read_data      in   32  from rvx_uart read_data
//   uart_read_request   out  1   to rvx_uart read_request
//   uart_read_response  in   1   from rvx_uart read_response
//   uart_write_data     out  8   to rvx_uart write_data
//   uart_write_request  out  1   to rvx_uart write_request
//   uart_write_response in   1   from rvx_uart write_response
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - All outputs 0; FIFO empty; level 0; overflow 0; FSM IDLE.
//     - Reset mid-transfer abandons the byte in flight; no further UART strobes.
//   CPU side:
//     - read_response and write_response = request delayed one cycle.
//     - read_data is loaded the cycle after a read; it is 0 on every other cycle.
//   CPU register map:
//     - 0x00 TXDATA, write: push write_data[7:0]. If the FIFO is full at that edge, the byte is
//       dropped and overflow is set. A pop in the same cycle does not rescue the push.
//     - 0x04 STATUS, read: {22'b0, level[PTR_WIDTH:0] in bits 9..5, 2'b0, overflow, full, empty}.
//       Field placement assumes default PTR_WIDTH. Reading STATUS clears overflow; a set event in
//       the same cycle wins.
//     - Other addresses: reads return 0; writes are ignored but still acked.
//   FIFO:
//     - Read and write pointers wrap modulo FIFO_DEPTH.
//     - Simultaneous push (not full) and pop: both occur and level is unchanged.
//     - full = (level == FIFO_DEPTH); empty = (level == 0).
//   Drain FSM (exactly one UART strobe outstanding at any time):
//     - IDLE: if !empty -> POLL.
//     - POLL: uart_rw_address=0x08, uart_read_request=1 for 1 cycle -> POLL_WAIT.
//     - POLL_WAIT: on uart_read_response, check uart_read_data[0]. If 1 -> WRITE, else -> POLL
//       (re-poll next cycle).
//     - WRITE: uart_rw_address=0x00, uart_write_data=head, uart_write_request=1 for 1 cycle.
//       Pop the head on this edge -> WRITE_WAIT.
//     - WRITE_WAIT: on uart_write_response -> IDLE.
//     - Strobes are single-cycle pulses. uart_rw_address holds its value through the wait state and
//       returns to 0 in IDLE.
//   Latency:
//     - Push into an empty FIFO when the UART is idle: POLL on cycle +1, WRITE on cycle +3.
//     - The byte is in the UART tx shifter by cycle +4.
// TESTING
//   1. Reset, then push 0x55, UART idle -> uart_write_request pulses with uart_write_data=0x55 three
//      cycles after the push ack; STATUS then reads empty=1.
//   2. Push 0x41,0x42,0x43 back-to-back -> UART receives 0x41,0x42,0x43 in order, each WRITE only
//      after a poll returns READY=1; polls repeat while the UART model returns 0.
//   3. Hold UART READY=0, push 17 bytes (DEPTH 16) -> STATUS=full=1, overflow=1, level=16.
//      A second STATUS read shows overflow=0. The 17th byte is never transmitted.
//   4. FIFO at level 5, push while FSM is in WRITE -> level stays 5; order preserved across pointer
//      wrap after 20 total bytes.
//   5. Assert reset_n=0 during POLL_WAIT -> all outputs 0 asynchronously, FIFO empty. After release,
//      no UART strobe until a new push.
//   6. Read addr 0x10 -> read_response=1 next cycle, read_data=0; write to 0x10 -> acked, level
//      unchanged.

Source files
------------

// File: rtl/rvx_uart_tx_fifo_if.sv
// IO-bus port bundle shared by the CPU-facing and UART-facing sides of the transmit buffer.
// The master issues address and strobes; the slave returns data and single-cycle acks.
interface rvx_uart_tx_fifo_if;
   logic [4:0]  rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [7:0]  write_data;
   logic        write_request;
   logic        write_response;

   modport master (
      output rw_address,
      output read_request,
      output write_data,
      output write_request,
      input  read_data,
      input  read_response,
      input  write_response
   );

   modport slave (
      input  rw_address,
      input  read_request,
      input  write_data,
      input  write_request,
      output read_data,
      output read_response,
      output write_response
   );
endinterface

// File: rtl/rvx_uart_tx_fifo.sv
// Transmit buffer in front of rvx_uart: CPU pushes bytes into a FIFO, and a drain FSM
// polls the UART READY register and writes each byte to WDATA without CPU involvement.
module rvx_uart_tx_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_WIDTH  = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   rvx_uart_tx_fifo_if.slave  cpu,
   rvx_uart_tx_fifo_if.master uart
);
   localparam logic [4:0] ADDR_TXDATA     = 5'h00;
   localparam logic [4:0] ADDR_STATUS     = 5'h04;
   localparam logic [4:0] ADDR_UART_WDATA = 5'h00;
   localparam logic [4:0] ADDR_UART_READY = 5'h08;
   localparam logic [PTR_WIDTH:0] LEVEL_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      POLL_WAIT,
      WRITE,
      WRITE_WAIT
   } state_t;

   state_t                 state_reg, state_next;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [7:0]             head_reg;
   logic [PTR_WIDTH-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [PTR_WIDTH:0]     level_reg, level_next;
   logic                   overflow_reg, overflow_next;
   logic [31:0]            read_data_reg, read_data_next, status_word;
   logic                   read_response_reg, write_response_reg;
   logic                   full, empty, push_req, push, pop, status_read;
   logic                   ready_bits_unused;

   assign full        = (level_reg == LEVEL_FULL);
   assign empty       = (level_reg == '0);
   assign push_req    = cpu.write_request && (cpu.rw_address == ADDR_TXDATA);
   // A pop on the same edge never makes room for a push into a full FIFO.
   assign push        = push_req && !full;
   assign pop         = (state_reg == WRITE);
   assign status_read = cpu.read_request && (cpu.rw_address == ADDR_STATUS);

   assign ready_bits_unused = ^uart.read_data[31:1];

   always_comb begin
      status_word                    = '0;
      status_word[5 +: PTR_WIDTH+1]  = level_reg;
      status_word[2]                 = overflow_reg;
      status_word[1]                 = full;
      status_word[0]                 = empty;
   end

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // A dropped push in the same cycle as a STATUS read leaves overflow set.
   always_comb begin
      overflow_next = overflow_reg;
      if (status_read) begin
         overflow_next = 1'b0;
      end
      if (push_req && full) begin
         overflow_next = 1'b1;
      end
   end

   always_comb begin
      read_data_next = '0;
      if (status_read) begin
         read_data_next = status_word;
      end
   end

   // Storage array with registered head read; rd_ptr is stable from POLL through WRITE.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg] <= cpu.write_data;
      end
      head_reg <= mem[rd_ptr_reg];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         level_reg          <= '0;
         overflow_reg       <= 1'b0;
         read_data_reg      <= '0;
         read_response_reg  <= 1'b0;
         write_response_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         level_reg          <= level_next;
         overflow_reg       <= overflow_next;
         read_data_reg      <= read_data_next;
         read_response_reg  <= cpu.read_request;
         write_response_reg <= cpu.write_request;
      end
   end

   assign cpu.read_data      = read_data_reg;
   assign cpu.read_response  = read_response_reg;
   assign cpu.write_response = write_response_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Moore outputs: exactly one UART strobe is ever outstanding.
   always_comb begin
      state_next         = state_reg;
      uart.rw_address    = '0;
      uart.read_request  = 1'b0;
      uart.write_request = 1'b0;
      uart.write_data    = '0;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               state_next = POLL;
            end
         end
         POLL: begin
            uart.rw_address   = ADDR_UART_READY;
            uart.read_request = 1'b1;
            state_next        = POLL_WAIT;
         end
         POLL_WAIT: begin
            uart.rw_address = ADDR_UART_READY;
            if (uart.read_response) begin
               state_next = uart.read_data[0] ? WRITE : POLL;
            end
         end
         WRITE: begin
            uart.rw_address    = ADDR_UART_WDATA;
            uart.write_data    = head_reg;
            uart.write_request = 1'b1;
            state_next         = WRITE_WAIT;
         end
         WRITE_WAIT: begin
            uart.rw_address = ADDR_UART_WDATA;
            if (uart.write_response) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_rvx_uart_tx_fifo.sv
// Bench for rvx_uart_tx_fifo: directed scenarios plus random traffic, checked against a
// queue-based model of the buffer and a behavioural UART that answers polls and writes.
module tb_rvx_uart_tx_fifo;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   rvx_uart_tx_fifo_if cpu_bus ();
   rvx_uart_tx_fifo_if uart_bus ();

   rvx_uart_tx_fifo #(
      .FIFO_DEPTH (16),
      .PTR_WIDTH  (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .cpu     (cpu_bus),
      .uart    (uart_bus)
   );

   int          vec_count   = 0;
   int          miscompares = 0;
   logic [7:0]  mq[$];
   logic        m_ovf;
   logic        prev_rreq, prev_wreq;
   logic [31:0] exp_rdata;
   logic        pend_rr, pend_wr, outstanding, granted;
   int          ready_pct;
   int          cycle_no;
   int          first_poll, first_ack, first_write;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle_no);
      end
   endtask

   function automatic logic [31:0] model_status();
      return {22'b0, 5'(mq.size()), 2'b0, m_ovf, (mq.size() == 16), (mq.size() == 0)};
   endfunction

   // Inputs for the current cycle are already applied; check outputs, advance the model.
   task automatic finish_cycle();
      logic push_req, status_rd, full, had_data, rdy;
      check_value("rd_resp", 32'(cpu_bus.read_response), 32'(prev_rreq));
      check_value("wr_resp", 32'(cpu_bus.write_response), 32'(prev_wreq));
      check_value("rd_data", cpu_bus.read_data, exp_rdata);
      if (cpu_bus.write_response && first_ack < 0) first_ack = cycle_no;
      had_data = (mq.size() != 0);
      if (uart_bus.read_request) begin
         if (first_poll < 0) first_poll = cycle_no;
         check_value("poll_addr", 32'(uart_bus.rw_address), 32'h08);
         check_value("poll_nonempty", 32'(had_data), 32'd1);
         check_value("poll_single", 32'(outstanding), 32'd0);
         outstanding = 1'b1;
         pend_rr     = 1'b1;
      end
      if (uart_bus.write_request) begin
         if (first_write < 0) first_write = cycle_no;
         check_value("tx_addr", 32'(uart_bus.rw_address), 32'h00);
         check_value("tx_after_ready", 32'(granted), 32'd1);
         check_value("tx_single", 32'(outstanding), 32'd0);
         check_value("tx_nonempty", 32'(had_data), 32'd1);
         if (had_data) check_value("tx_byte", 32'(uart_bus.write_data), 32'(mq[0]));
         $display("uart tx byte 0x%02h at cycle %0d", uart_bus.write_data, cycle_no);
         granted     = 1'b0;
         outstanding = 1'b1;
         pend_wr     = 1'b1;
      end
      push_req  = cpu_bus.write_request && (cpu_bus.rw_address == 5'h00);
      status_rd = cpu_bus.read_request && (cpu_bus.rw_address == 5'h04);
      exp_rdata = status_rd ? model_status() : 32'h0;
      prev_rreq = cpu_bus.read_request;
      prev_wreq = cpu_bus.write_request;
      full      = (mq.size() == 16);
      if (status_rd) m_ovf = 1'b0;
      if (push_req) begin
         if (full) m_ovf = 1'b1;
         else      mq.push_back(cpu_bus.write_data);
      end
      if (uart_bus.write_request && had_data) void'(mq.pop_front());
      @(negedge clock);
      rdy = ($urandom_range(99) < ready_pct);
      uart_bus.read_response  = pend_rr;
      uart_bus.read_data      = pend_rr ? {31'b0, rdy} : 32'h0;
      uart_bus.write_response = pend_wr;
      if (pend_rr) begin
         outstanding = 1'b0;
         granted     = rdy;
      end
      if (pend_wr) outstanding = 1'b0;
      pend_rr = 1'b0;
      pend_wr = 1'b0;
      cycle_no++;
   endtask

   // op: 0 idle, 1 write, 2 read
   task automatic drive(input int op, input logic [4:0] addr, input logic [7:0] data);
      cpu_bus.rw_address    = addr;
      cpu_bus.read_request  = (op == 2);
      cpu_bus.write_request = (op == 1);
      cpu_bus.write_data    = data;
      finish_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 5'h00, 8'h00);
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      ready_pct = 100;
      while (mq.size() != 0 && n < bound) begin
         drive(0, 5'h00, 8'h00);
         n++;
      end
      check_value(tag, 32'(mq.size()), 32'd0);
      idle(4);
   endtask

   task automatic do_reset();
      reset_n                 = 1'b0;
      cpu_bus.rw_address      = '0;
      cpu_bus.read_request    = 1'b0;
      cpu_bus.write_request   = 1'b0;
      cpu_bus.write_data      = '0;
      uart_bus.read_response  = 1'b0;
      uart_bus.read_data      = '0;
      uart_bus.write_response = 1'b0;
      #1;
      check_value("rst_uart_rreq", 32'(uart_bus.read_request), 32'd0);
      check_value("rst_uart_wreq", 32'(uart_bus.write_request), 32'd0);
      check_value("rst_uart_addr", 32'(uart_bus.rw_address), 32'd0);
      check_value("rst_uart_wdata", 32'(uart_bus.write_data), 32'd0);
      check_value("rst_cpu_rdata", cpu_bus.read_data, 32'd0);
      check_value("rst_cpu_rresp", 32'(cpu_bus.read_response), 32'd0);
      check_value("rst_cpu_wresp", 32'(cpu_bus.write_response), 32'd0);
      mq.delete();
      m_ovf       = 1'b0;
      prev_rreq   = 1'b0;
      prev_wreq   = 1'b0;
      exp_rdata   = '0;
      pend_rr     = 1'b0;
      pend_wr     = 1'b0;
      outstanding = 1'b0;
      granted     = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int c0, n, r;
      logic saw;
      cycle_no  = 0;
      ready_pct = 100;
      @(negedge clock);
      do_reset();

      // Single byte latency with an idle UART.
      first_poll = -1; first_ack = -1; first_write = -1;
      c0 = cycle_no;
      drive(1, 5'h00, 8'h55);
      idle(8);
      check_value("t1_ack_lat", 32'(first_ack - c0), 32'd1);
      check_value("t1_poll_lat", 32'(first_poll - c0), 32'd2);
      check_value("t1_write_lat", 32'(first_write - c0), 32'd4);
      drive(2, 5'h04, 8'h00);
      check_value("t1_status", cpu_bus.read_data, 32'h0000_0001);
      idle(2);

      // Back-to-back pushes with a sometimes-busy UART.
      ready_pct = 30;
      drive(1, 5'h00, 8'h41);
      drive(1, 5'h00, 8'h42);
      drive(1, 5'h00, 8'h43);
      n = 0;
      while (mq.size() != 0 && n < 300) begin
         drive(0, 5'h00, 8'h00);
         n++;
      end
      check_value("t2_drained", 32'(mq.size()), 32'd0);
      idle(4);

      // Overflow with the UART never ready.
      ready_pct = 0;
      for (int i = 0; i < 17; i++) drive(1, 5'h00, 8'($urandom));
      drive(2, 5'h04, 8'h00);
      check_value("t3_status1", cpu_bus.read_data, 32'h0000_0206);
      drive(2, 5'h04, 8'h00);
      check_value("t3_status2", cpu_bus.read_data, 32'h0000_0202);
      drain("t3_drain", 400);

      // Push on the same edge as a pop keeps the level.
      ready_pct = 0;
      for (int i = 0; i < 5; i++) drive(1, 5'h00, 8'(8'h90 + i));
      idle(3);
      ready_pct = 100;
      saw = 1'b0;
      n = 0;
      while (!saw && n < 50) begin
         if (uart_bus.write_request) begin
            saw = 1'b1;
            drive(1, 5'h00, 8'hA5);
         end else begin
            drive(0, 5'h00, 8'h00);
         end
         n++;
      end
      check_value("t4_saw_write", 32'(saw), 32'd1);
      drive(2, 5'h04, 8'h00);
      check_value("t4_level", (cpu_bus.read_data >> 5) & 32'h1f, 32'd5);
      drain("t4_drain", 200);

      // Reset while waiting on a poll response.
      ready_pct = 0;
      drive(1, 5'h00, 8'h11);
      drive(1, 5'h00, 8'h22);
      n = 0;
      while (!uart_bus.read_request && n < 20) begin
         drive(0, 5'h00, 8'h00);
         n++;
      end
      check_value("t5_poll_seen", 32'(uart_bus.read_request), 32'd1);
      drive(0, 5'h00, 8'h00);
      check_value("t5_wait_addr", 32'(uart_bus.rw_address), 32'h08);
      do_reset();
      ready_pct = 100;
      idle(20);
      drive(2, 5'h04, 8'h00);
      check_value("t5_status", cpu_bus.read_data, 32'h0000_0001);

      // Unmapped address accesses.
      drive(2, 5'h10, 8'h00);
      check_value("t6_rresp", 32'(cpu_bus.read_response), 32'd1);
      check_value("t6_rdata", cpu_bus.read_data, 32'd0);
      drive(1, 5'h10, 8'h77);
      check_value("t6_wresp", 32'(cpu_bus.write_response), 32'd1);
      drive(2, 5'h04, 8'h00);
      check_value("t6_status", cpu_bus.read_data, 32'h0000_0001);

      // Random traffic.
      for (int seg = 0; seg < 6; seg++) begin
         ready_pct = $urandom_range(100);
         for (int i = 0; i < 100; i++) begin
            r = $urandom_range(99);
            if (r < 35)      drive(1, 5'h00, 8'($urandom));
            else if (r < 50) drive(2, 5'h04, 8'h00);
            else if (r < 60) drive(2, 5'($urandom), 8'h00);
            else if (r < 70) drive(1, 5'($urandom), 8'($urandom));
            else             drive(0, 5'h00, 8'h00);
         end
      end
      drain("t7_drain", 400);
      drive(2, 5'h04, 8'h00);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end
endmodule
